// File: rtl/spi_sched_pkg.sv
`default_nettype none
// spi_sched_pkg: shared state encoding and counter-width helpers for spi_frame_scheduler.
package spi_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_START = 3'd2,
        S_BUSY  = 3'd3,
        S_GAP   = 3'd4
    } sched_state_t;

    // Bits needed to count 0 .. n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_GAP_CYCLES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int DEF_GAP_CNT_W      = cnt_width(DEF_GAP_CYCLES);
    localparam int DEF_TMO_CNT_W      = cnt_width(DEF_TIMEOUT_CYCLES);

endpackage
`default_nettype wire

// File: rtl/spi_frame_scheduler_rr_pick.sv
`default_nettype none
// rr_pick: combinational circular search for the first eligible index after last_i.
module rr_pick #(
    parameter int N_SLAVES = 3,
    parameter int SEL_W    = $clog2(N_SLAVES)
) (
    input  logic [N_SLAVES-1:0] elig_i,
    input  logic [SEL_W-1:0]    last_i,
    output logic [SEL_W-1:0]    idx_o,
    output logic                found_o
);

    always_comb begin
        int c;
        idx_o   = '0;
        found_o = 1'b0;
        c       = 0;
        for (int k = 1; k <= N_SLAVES; k++) begin
            c = (int'(last_i) + k) % N_SLAVES;
            if (!found_o && elig_i[c]) begin
                found_o = 1'b1;
                idx_o   = SEL_W'(c);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_frame_scheduler.sv
`default_nettype none
// spi_frame_scheduler: masked round-robin frame scheduler for one shared SPI byte master.
// Build macro SPI_SCHED_TIMEOUT_EN adds a BUSY watchdog with abort pulse and sticky flags.
module spi_frame_scheduler
    import spi_sched_pkg::*;
#(
    parameter int N_SLAVES       = 3,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int SEL_W          = $clog2(N_SLAVES)
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic [N_SLAVES-1:0] req_bus,
    input  logic [N_SLAVES-1:0] enable_mask,
    input  logic                frame_done,
    input  logic                err_clr,
    output logic                start,
    output logic [SEL_W-1:0]    select,
    output logic [N_SLAVES-1:0] grant_bus,
    output logic [N_SLAVES-1:0] n_cs_bus,
    output logic                idle,
    output logic                abort,
    output logic [N_SLAVES-1:0] timeout_bus
);

    localparam int GAP_W = cnt_width(GAP_CYCLES);

    sched_state_t        state_q, state_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [N_SLAVES-1:0] grant_q, grant_d;
    logic [N_SLAVES-1:0] ncs_q, ncs_d;
    logic                start_q, start_d;
    logic                idle_q, idle_d;

    logic [N_SLAVES-1:0] elig;
    logic [SEL_W-1:0]    pick_idx;
    logic                pick_found;
    logic                expire;

    assign elig = req_bus & enable_mask;

    rr_pick #(
        .N_SLAVES (N_SLAVES),
        .SEL_W    (SEL_W)
    ) u_rr_pick (
        .elig_i  (elig),
        .last_i  (last_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        last_d  = last_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|elig) state_d = S_ARB;
            end
            S_ARB: begin
                // Eligibility is re-evaluated here; a request dropped since IDLE falls back.
                if (pick_found) begin
                    state_d           = S_START;
                    last_d            = pick_idx;
                    sel_d             = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    start_d           = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: state_d = S_BUSY;
            S_BUSY: begin
                if (frame_done || expire) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    grant_d = '0;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = S_IDLE;
                else                                  gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        ncs_d  = (state_d == S_START || state_d == S_BUSY) ? ~grant_d : '1;
        idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            last_q  <= SEL_W'(N_SLAVES - 1);
            sel_q   <= '0;
            grant_q <= '0;
            ncs_q   <= '1;
            start_q <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            ncs_q   <= ncs_d;
            start_q <= start_d;
            idle_q  <= idle_d;
        end
    end

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);

    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [N_SLAVES-1:0] tflag_q, tflag_d;
    logic                abort_q;

    // frame_done in the expiry cycle takes priority, so it masks the abort.
    always_comb begin
        tmo_d   = (state_q == S_BUSY) ? tmo_q + 1'b1 : '0;
        expire  = (state_q == S_BUSY) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) && !frame_done;
        tflag_d = err_clr ? '0 : tflag_q;
        if (expire) tflag_d[sel_q] = 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tmo_q   <= '0;
            tflag_q <= '0;
            abort_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            tflag_q <= tflag_d;
            abort_q <= expire;
        end
    end

    assign abort       = abort_q;
    assign timeout_bus = tflag_q;
`else
    logic unused_ok;

    assign expire      = 1'b0;
    assign abort       = 1'b0;
    assign timeout_bus = '0;
    assign unused_ok   = err_clr ^ (TIMEOUT_CYCLES > 1);
`endif

    assign start     = start_q;
    assign select    = sel_q;
    assign grant_bus = grant_q;
    assign n_cs_bus  = ncs_q;
    assign idle      = idle_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_scheduler.sv
`default_nettype none
// tb_spi_frame_scheduler: vector table, directed corner sequences and a randomized reference-model run.
module tb_spi_frame_scheduler;

    localparam int N   = 3;
    localparam int GAP = 4;
    localparam int TMO = 16;
    localparam int SW  = 2;

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_ARB   = 1;
    localparam int M_START = 2;
    localparam int M_BUSY  = 3;
    localparam int M_GAP   = 4;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_bus, enable_mask;
    logic          frame_done, err_clr;
    logic          start, idle, abort;
    logic [SW-1:0] select;
    logic [N-1:0]  grant_bus, n_cs_bus, timeout_bus;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    spi_frame_scheduler #(
        .N_SLAVES       (N),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .SEL_W          (SW)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .req_bus     (req_bus),
        .enable_mask (enable_mask),
        .frame_done  (frame_done),
        .err_clr     (err_clr),
        .start       (start),
        .select      (select),
        .grant_bus   (grant_bus),
        .n_cs_bus    (n_cs_bus),
        .idle        (idle),
        .abort       (abort),
        .timeout_bus (timeout_bus)
    );

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  mask;
        logic          done;
        logic          e_start;
        logic [SW-1:0] e_sel;
        logic [N-1:0]  e_grant;
        logic [N-1:0]  e_ncs;
        logic          e_idle;
    } vec_t;

    vec_t tbl [19];

    // Reference model state
    int           m_ph, m_last, m_sel, m_age, m_gap;
    logic [N-1:0] m_to;
    logic         e_start, e_abort, e_idle;
    logic [N-1:0] e_grant, e_ncs;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_bus = '0; enable_mask = '1; frame_done = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_start_seen"}, 32'(start), 32'd1);
    endtask

    // Winner is the eligible index at the smallest circular distance past 'last'.
    function automatic int rr_ref(input int last, input logic [N-1:0] elig);
        int best, bd, d;
        best = -1;
        bd   = N + 1;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                d = (i - last - 1 + 2 * N) % N;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_step();
        int           w;
        logic [N-1:0] set_v;
        set_v   = '0;
        e_start = 1'b0;
        e_abort = 1'b0;
        if (rst) begin
            m_ph = M_IDLE; m_last = N - 1; m_sel = 0; m_to = '0; m_age = 0; m_gap = 0;
        end else begin
            case (m_ph)
                M_IDLE: if ((req_bus & enable_mask) != '0) m_ph = M_ARB;
                M_ARB: begin
                    w = rr_ref(m_last, req_bus & enable_mask);
                    if (w < 0) m_ph = M_IDLE;
                    else begin
                        m_last = w; m_sel = w; e_start = 1'b1; m_ph = M_START;
                    end
                end
                M_START: begin m_ph = M_BUSY; m_age = 0; end
                M_BUSY: begin
                    m_age++;
                    if (frame_done) begin
                        m_ph = M_GAP; m_gap = GAP;
                    end else if (TO_EN && m_age == TMO) begin
                        e_abort = 1'b1; set_v[m_sel] = 1'b1; m_ph = M_GAP; m_gap = GAP;
                    end
                end
                default: begin
                    m_gap--;
                    if (m_gap == 0) m_ph = M_IDLE;
                end
            endcase
            m_to = (err_clr ? '0 : m_to) | set_v;
        end
        e_grant = '0;
        e_ncs   = '1;
        if (m_ph == M_START || m_ph == M_BUSY) begin
            e_grant[m_sel] = 1'b1;
            e_ncs          = ~e_grant;
        end
        e_idle = (m_ph == M_IDLE);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{3'b001, 3'b111, 1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 1'b0};
        tbl[1]  = '{3'b001, 3'b111, 1'b0, 1'b1, 2'd0, 3'b001, 3'b110, 1'b0};
        tbl[2]  = '{3'b000, 3'b111, 1'b0, 1'b0, 2'd0, 3'b001, 3'b110, 1'b0};
        tbl[3]  = '{3'b000, 3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 3'b111, 1'b0};
        tbl[4]  = '{3'b000, 3'b111, 1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 1'b0};
        tbl[5]  = '{3'b000, 3'b111, 1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 1'b0};
        tbl[6]  = '{3'b000, 3'b111, 1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 1'b0};
        tbl[7]  = '{3'b000, 3'b111, 1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 1'b1};
        tbl[8]  = '{3'b000, 3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 3'b111, 1'b1};
        tbl[9]  = '{3'b010, 3'b111, 1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 1'b0};
        tbl[10] = '{3'b000, 3'b111, 1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 1'b1};
        tbl[11] = '{3'b101, 3'b011, 1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 1'b0};
        tbl[12] = '{3'b101, 3'b011, 1'b0, 1'b1, 2'd0, 3'b001, 3'b110, 1'b0};
        tbl[13] = '{3'b101, 3'b111, 1'b0, 1'b0, 2'd0, 3'b001, 3'b110, 1'b0};
        tbl[14] = '{3'b000, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 3'b111, 1'b0};
        tbl[15] = '{3'b000, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 1'b0};
        tbl[16] = '{3'b000, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 1'b0};
        tbl[17] = '{3'b000, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 1'b0};
        tbl[18] = '{3'b000, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 3'b111, 1'b1};

        // Reset values
        do_reset();
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_select", 32'(select), 32'd0);
        chk("rst_grant", 32'(grant_bus), 32'd0);
        chk("rst_ncs", 32'(n_cs_bus), 32'h7);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_timeout", 32'(timeout_bus), 32'd0);

        // Cycle-by-cycle vector table
        for (int i = 0; i < 19; i++) begin
            req_bus = tbl[i].req; enable_mask = tbl[i].mask; frame_done = tbl[i].done;
            tick();
            chk($sformatf("tbl%0d_start", i), 32'(start), 32'(tbl[i].e_start));
            chk($sformatf("tbl%0d_select", i), 32'(select), 32'(tbl[i].e_sel));
            chk($sformatf("tbl%0d_grant", i), 32'(grant_bus), 32'(tbl[i].e_grant));
            chk($sformatf("tbl%0d_ncs", i), 32'(n_cs_bus), 32'(tbl[i].e_ncs));
            chk($sformatf("tbl%0d_idle", i), 32'(idle), 32'(tbl[i].e_idle));
        end
        frame_done = 1'b0;

        // Round robin with all slaves requesting
        do_reset();
        req_bus = 3'b111; enable_mask = 3'b111;
        for (int f = 0; f < 6; f++) begin
            wait_start("rr");
            chk($sformatf("rr%0d_select", f), 32'(select), 32'(f % 3));
            chk($sformatf("rr%0d_grant", f), 32'(grant_bus), 32'(1 << (f % 3)));
            chk($sformatf("rr%0d_ncs", f), 32'(n_cs_bus), 32'(3'b111 & ~(3'(1 << (f % 3)))));
            tick();
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
        end

        // Masked slave never served
        do_reset();
        req_bus = 3'b101; enable_mask = 3'b011;
        for (int f = 0; f < 4; f++) begin
            wait_start("mask");
            chk($sformatf("mask%0d_select", f), 32'(select), 32'd0);
            chk($sformatf("mask%0d_grant", f), 32'(grant_bus), 32'd1);
            tick();
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
        end

        // Reset during BUSY
        do_reset();
        req_bus = 3'b111; enable_mask = 3'b111;
        wait_start("mrst0");
        tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        wait_start("mrst1");
        chk("mrst1_select", 32'(select), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_ncs", 32'(n_cs_bus), 32'h7);
        chk("mrst_grant", 32'(grant_bus), 32'd0);
        chk("mrst_idle", 32'(idle), 32'd1);
        chk("mrst_start", 32'(start), 32'd0);
        chk("mrst_abort", 32'(abort), 32'd0);
        rst = 1'b0;
        wait_start("mrst2");
        chk("mrst2_select", 32'(select), 32'd0);
        tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;

        // Watchdog behaviour
        do_reset();
        req_bus = 3'b001; enable_mask = 3'b111;
        wait_start("wd");
        if (TO_EN) begin
            for (int k = 1; k <= TMO; k++) begin
                tick();
                chk($sformatf("wd_busy%0d_abort", k), 32'(abort), 32'd0);
            end
            tick();
            chk("wd_abort", 32'(abort), 32'd1);
            chk("wd_flag", 32'(timeout_bus), 32'd1);
            chk("wd_ncs", 32'(n_cs_bus), 32'h7);
            tick();
            chk("wd_abort_pulse", 32'(abort), 32'd0);
            chk("wd_flag_sticky", 32'(timeout_bus), 32'd1);
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            chk("wd_flag_clr", 32'(timeout_bus), 32'd0);
            wait_start("wd2");
            for (int k = 1; k <= TMO; k++) tick();
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
            chk("wd2_abort", 32'(abort), 32'd0);
            chk("wd2_flag", 32'(timeout_bus), 32'd0);
            chk("wd2_ncs", 32'(n_cs_bus), 32'h7);
        end else begin
            for (int k = 1; k <= 2 * TMO; k++) begin
                tick();
                chk($sformatf("nowd%0d_abort", k), 32'(abort), 32'd0);
            end
            chk("nowd_ncs", 32'(n_cs_bus), 32'h6);
            chk("nowd_flag", 32'(timeout_bus), 32'd0);
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
        end

        // Randomized run against the reference model
        for (int c = 0; c < 3000; c++) begin
            int rate;
            rate        = (TO_EN && ((c / 600) % 2 == 1)) ? 40 : 4;
            rst         = (c == 0) || ($urandom_range(0, 299) == 0);
            req_bus     = 3'($urandom_range(0, 7));
            enable_mask = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            frame_done  = ($urandom_range(0, rate - 1) == 0);
            err_clr     = ($urandom_range(0, 15) == 0);
            model_step();
            tick();
            chk($sformatf("rand%0d", c),
                32'({start, select, grant_bus, n_cs_bus, idle, abort, timeout_bus}),
                32'({e_start, SW'(m_sel), e_grant, e_ncs, e_idle, e_abort, m_to}));
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
